// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter with grant hold until release; registered one-hot and binary grant outputs.
// Optional forced release after MAX_HOLD cycles is compiled in with `define RR_ARB_HOLD_TIMEOUT_EN.
module rr_arbiter_param #(
  parameter  int NUM_PORTS = 5,
  parameter  int MAX_HOLD  = 16,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 release_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 gnt_valid_o,
  output logic                 timeout_o,
  output logic                 dbg_state_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_ptr;
  logic [NUM_PORTS-1:0]   r_gnt;
  logic [IDX_W-1:0]       r_gnt_idx;
  logic                   r_gnt_valid;
  logic                   r_timeout;

  logic                   w_found;
  logic [IDX_W-1:0]       w_win;
  logic [IDX_W-1:0]       w_cand;
  logic                   w_rel_ext;
  logic                   w_to_hit;
  logic                   w_release;
  logic                   w_do_grant;
  logic                   w_go_idle;
  logic [NUM_PORTS-1:0]   w_gnt_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [IDX_W-1:0]       w_ptr_nxt;

  // Search upward from r_ptr with wrap; the holder sits at ptr-1, so it is checked last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(r_ptr) + i >= NUM_PORTS)
        w_cand = IDX_W'(int'(r_ptr) + i - NUM_PORTS);
      else
        w_cand = IDX_W'(int'(r_ptr) + i);
      if (!w_found && req_i[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_rel_ext = release_i | ~req_i[r_gnt_idx];

`ifdef RR_ARB_HOLD_TIMEOUT_EN
  logic [7:0] r_hold_cnt;

  assign w_to_hit = (r_state == ST_HOLD) && !w_rel_ext &&
                    (r_hold_cnt == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_hold_cnt <= '0;
    else if (w_do_grant || r_state != ST_HOLD)
      r_hold_cnt <= '0;
    else
      r_hold_cnt <= r_hold_cnt + 8'd1;
  end
`else
  // Constant false; MAX_HOLD only matters when the counter is compiled in.
  assign w_to_hit = (MAX_HOLD < 0);
`endif

  assign w_release  = (r_state == ST_HOLD) && (w_rel_ext || w_to_hit);
  assign w_do_grant = ((r_state == ST_IDLE) || w_release) && w_found;
  assign w_go_idle  = w_release && !w_found;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_do_grant)
      w_state_nxt = ST_HOLD;
    else if (w_go_idle)
      w_state_nxt = ST_IDLE;
  end

  // Output logic: next values for the registered grant outputs
  always_comb begin
    w_gnt_nxt = r_gnt;
    w_idx_nxt = r_gnt_idx;
    w_ptr_nxt = r_ptr;
    if (w_do_grant) begin
      w_gnt_nxt        = '0;
      w_gnt_nxt[w_win] = 1'b1;
      w_idx_nxt        = w_win;
      w_ptr_nxt        = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
    end else if (w_go_idle || r_state == ST_IDLE) begin
      w_gnt_nxt = '0;
      w_idx_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_timeout   <= w_to_hit;
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_idx_o   = r_gnt_idx;
  assign gnt_valid_o = r_gnt_valid;
  assign timeout_o   = r_timeout;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench for rr_arbiter_param (5 ports, MAX_HOLD = 4); timeout checks follow RR_ARB_HOLD_TIMEOUT_EN.
module tb_rr_arbiter_param;

  localparam int N = 5;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_i;
  logic         release_i;
  logic [N-1:0] gnt_o;
  logic [2:0]   gnt_idx_o;
  logic         gnt_valid_o;
  logic         timeout_o;
  logic         dbg_state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];

  rr_arbiter_param #(.NUM_PORTS(N), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .release_i   (release_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .timeout_o   (timeout_o),
    .dbg_state_o (dbg_state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full grant check: one-hot vector derived from the expected index.
  task automatic check_gnt(input string tag, input logic valid, input logic [2:0] idx);
    logic [N-1:0] exp_gnt;
    exp_gnt = '0;
    if (valid) exp_gnt[idx] = 1'b1;
    check({tag, ".gnt"},   32'(gnt_o),       32'(exp_gnt));
    check({tag, ".idx"},   32'(gnt_idx_o),   32'(valid ? idx : 3'd0));
    check({tag, ".valid"}, 32'(gnt_valid_o), 32'(valid));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_i     = '0;
    release_i = 1'b0;
    step();
    step();
    check_gnt("reset", 1'b0, 3'd0);
    check("reset.timeout", 32'(timeout_o), 32'd0);
    check("reset.state", 32'(dbg_state_o), 32'd0);
    rst_n = 1'b1;
    step();
    check_gnt("idle_no_req", 1'b0, 3'd0);

    // Rotation: all request, release every cycle
    req_i = 5'b11111;
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    step();
    check_gnt("rot0", 1'b1, exp_q.pop_front());
    release_i = 1'b1;
    while (exp_q.size() > 0) begin
      step();
      check_gnt("rot", 1'b1, exp_q.pop_front());
    end
    release_i = 1'b0;
    req_i     = '0;
    step();
    check_gnt("rot_idle", 1'b0, 3'd0);

    // Hold: ptr is 1, lone request on 3, then everyone requests
    req_i = 5'b01000;
    step();
    check_gnt("hold_start", 1'b1, 3'd3);
    req_i = 5'b11111;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_idx", 32'(gnt_idx_o), 32'd3);
    end
    release_i = 1'b1;
    step();
    check_gnt("hold_move", 1'b1, 3'd4);
    release_i = 1'b0;
    req_i     = '0;
    step();
    check_gnt("hold_idle", 1'b0, 3'd0);

    // Sole requester: ptr 0 -> port 1, release re-grants port 1
    req_i = 5'b00010;
    step();
    check_gnt("sole_first", 1'b1, 3'd1);
    release_i = 1'b1;
    step();
    check_gnt("sole_regrant", 1'b1, 3'd1);
    release_i = 1'b0;

    // Implicit release: holder 1 drops, ptr 2 -> port 2, then release -> port 0
    req_i = 5'b00101;
    step();
    check_gnt("impl_drop", 1'b1, 3'd2);
    release_i = 1'b1;
    step();
    check_gnt("impl_rel", 1'b1, 3'd0);
    release_i = 1'b0;
    req_i     = '0;
    step();
    check_gnt("impl_idle", 1'b0, 3'd0);

    // Asynchronous reset while holding port 2
    req_i = 5'b00100;
    step();
    check_gnt("pre_rst", 1'b1, 3'd2);
    rst_n = 1'b0;
    #1;
    check_gnt("async_rst", 1'b0, 3'd0);
    req_i = '0;
    step();
    rst_n = 1'b1;

    // Timeout: port 0 then 1 request, no release; ptr restarts at 0
    req_i = 5'b00011;
    step();
    check_gnt("to_grant", 1'b1, 3'd0);
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_hold_idx", 32'(gnt_idx_o), 32'd0);
      check("to_hold_pulse", 32'(timeout_o), 32'd0);
    end
    step();
    check_gnt("to_fire", 1'b1, 3'd1);
    check("to_fire_pulse", 32'(timeout_o), 32'd1);
    step();
    check("to_pulse_end", 32'(timeout_o), 32'd0);
    check("to_after_idx", 32'(gnt_idx_o), 32'd1);
`else
    for (int i = 0; i < 12; i++) begin
      step();
      check("nto_hold_idx", 32'(gnt_idx_o), 32'd0);
      check("nto_pulse", 32'(timeout_o), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
